o_sa_row_collector: RTL and testbench

Downstream stage of the systolic-array output column block. Accepts the per-column `{valid, data}` lanes, which leave the array skewed by one cycle per column, removes the skew, and assembles each aligned set into one row word. Rows are buffered in a small FIFO and handed on over a valid/ready handshake. Malformed (partially valid) rows and FIFO overflow are flagged with sticky error bits.

---
 rtl/o_sa_row_collector.sv | 208 ++++++++++++++++++++
 tb/tb_o_sa_row_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/o_sa_row_collector.sv
// o_sa_row_collector
//   Downstream stage of the systolic-array output column block. The per-column
//   {valid, data} lanes leave the array skewed by one cycle per column. This
//   block removes that skew, assembles each aligned set into one row word,
//   buffers rows in a small first-word-fall-through FIFO and hands them on
//   over a valid/ready handshake. Sticky flags report dropped rows (FIFO full)
//   and partially valid rows.
//
// Build option:
//   O_SA_COLLECT_SKEW_CHECK_EN  defined   : a row needs every aligned valid; a
//                                           partially valid row is discarded
//                                           and sets o_err.
//                               undefined : lane 0's aligned valid alone marks
//                                           a row, other lanes are captured
//                                           as-is, o_err is tied to 0.
//
// Parameters:
//   COL     number of array columns / lanes (>= 1)
//   W_DATA  data bits per lane (lane width W_DATA+1, valid at MSB)
//   DEPTH   row FIFO entries (power of two, >= 2)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clr        synchronous clear of o_overflow, o_err, o_row_count
//   i_data       lanes, lane 0 at MSB, each lane {valid, data}
//   i_row_ready  consumer accepts the head row
//   o_row        head row, lane 0 data at MSB (0 while empty)
//   o_row_valid  FIFO non-empty
//   o_row_count  rows written to the FIFO, wraps at 2^16
//   o_overflow   sticky: a complete row was dropped on a full FIFO
//   o_err        sticky: a partially valid aligned row was seen

// Per-lane deskew shift register: STAGES register stages, reset to zero.
module o_sa_row_collector_lane #(
  parameter int LW     = 9,
  parameter int STAGES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [LW-1:0] i_lane,
  output logic [LW-1:0] o_lane
);

  logic [LW-1:0] sr_q [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) sr_q[s] <= '0;
    end else begin
      sr_q[0] <= i_lane;
      for (int s = 1; s < STAGES; s++) sr_q[s] <= sr_q[s-1];
    end
  end

  assign o_lane = sr_q[STAGES-1];

endmodule

module o_sa_row_collector #(
  parameter int COL    = 3,
  parameter int W_DATA = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic [(W_DATA+1)*COL-1:0] i_data,
  input  logic                     i_row_ready,
  output logic [W_DATA*COL-1:0]    o_row,
  output logic                     o_row_valid,
  output logic [15:0]              o_row_count,
  output logic                     o_overflow,
  output logic                     o_err
);

  localparam int LW = W_DATA + 1;
  localparam int RW = W_DATA * COL;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------- deskew
  logic [COL-1:0]              al_v;
  logic [COL-1:0][W_DATA-1:0]  al_d;
  logic [RW-1:0]               al_row;

  // Lane i waits COL-i stages so lane 0 (presented first) and lane COL-1
  // (presented last) reach the row-event logic in the same cycle.
  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic [LW-1:0] lane_out;

    o_sa_row_collector_lane #(
      .LW     (LW),
      .STAGES (COL - i)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_lane  (i_data[LW*(COL-i)-1 -: LW]),
      .o_lane  (lane_out)
    );

    assign al_v[i] = lane_out[W_DATA];
    assign al_d[i] = lane_out[W_DATA-1:0];
    assign al_row[W_DATA*(COL-i)-1 -: W_DATA] = al_d[i];
  end

  // ------------------------------------------------------------- row event
  logic row_full;

`ifdef O_SA_COLLECT_SKEW_CHECK_EN
  logic row_part;
  assign row_full = &al_v;
  assign row_part = (|al_v) & ~row_full;
`else
  // Only lane 0 qualifies a row; the remaining valids are deliberately unused.
  logic unused_vld;
  assign row_full   = al_v[0];
  assign unused_vld = ^al_v;
`endif

  // ------------------------------------------------------------------ FIFO
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          empty, full, pop, push, drop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FULL_OCC);
  assign pop   = ~empty & i_row_ready;
  // A full FIFO still takes a row when the head leaves on the same edge.
  assign push  = row_full & (~full | pop);
  assign drop  = row_full & full & ~pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Storage needs no reset: nothing is visible until occupancy says so.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= al_row;
  end

  assign o_row_valid = ~empty;
  assign o_row       = o_row_valid ? mem_q[rptr_q] : '0;

  // ---------------------------------------------------- counter and flags
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  // Clear first, then apply this edge's event, so an event coinciding with
  // i_clr survives it.
  always_comb begin
    cnt_d = i_clr ? 16'd0 : cnt_q;
    if (push) cnt_d = cnt_d + 16'd1;
    ovf_d = (ovf_q & ~i_clr) | drop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_row_count = cnt_q;
  assign o_overflow  = ovf_q;

`ifdef O_SA_COLLECT_SKEW_CHECK_EN
  logic err_q, err_d;

  assign err_d = (err_q & ~i_clr) | row_part;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_o_sa_row_collector.sv
module tb_o_sa_row_collector;

  localparam int COL   = 3;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int IW    = (W + 1) * COL;
  localparam int RW    = W * COL;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          rdy   = 1'b0;
  logic [IW-1:0] din   = '0;
  logic [RW-1:0] o_row;
  logic          o_row_valid;
  logic [15:0]   o_row_count;
  logic          o_overflow;
  logic          o_err;

  always #5 clk = ~clk;

  o_sa_row_collector #(.COL(COL), .W_DATA(W), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clr       (clr),
    .i_data      (din),
    .i_row_ready (rdy),
    .o_row       (o_row),
    .o_row_valid (o_row_valid),
    .o_row_count (o_row_count),
    .o_overflow  (o_overflow),
    .o_err       (o_err)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            pops    = 0;
  int            run     = 0;
  int            max_run = 0;
  logic [RW-1:0] sb [$];          // expected rows, in order
  logic [RW-1:0] rd [$];          // rows to send: lane 0 data at MSB
  logic [COL-1:0] rv [$];         // per-row lane valids, bit i = lane i
  logic [RW-1:0] exp_row;
  logic [RW-1:0] keep;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted head row is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (o_row_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (rdy) begin
        pops++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL row_unexpected: got %06h expected none", o_row);
        end else begin
          exp_row = sb.pop_front();
          if (o_row !== exp_row) begin
            n_fail++;
            $display("FAIL row_data: got %06h expected %06h", o_row, exp_row);
          end
        end
      end
    end else begin
      run = 0;
    end
  end

  // Skewed lane word for stream cycle c: lane i carries row c-i.
  function automatic logic [IW-1:0] lanes(input int c, input int n);
    logic [IW-1:0] w;
    w = '0;
    for (int i = 0; i < COL; i++) begin
      int r;
      r = c - i;
      if (r >= 0 && r < n)
        w[(W+1)*(COL-i)-1 -: W+1] = {rv[r][i], rd[r][W*(COL-i)-1 -: W]};
    end
    return w;
  endfunction

  // Drives rd/rv back to back; row r is written at the end of cycle r+COL.
  // rdy_at / clr_at pulse i_row_ready / i_clr in that single cycle (-1: off).
  task automatic stream(input int n, input int rdy_at, input int clr_at);
    for (int c = 0; c < n + COL; c++) begin
      @(posedge clk); #1;
      din = lanes(c, n);
      if (rdy_at >= 0) rdy = (c == rdy_at);
      if (clr_at >= 0) clr = (c == clr_at);
    end
    if (rdy_at >= 0 || clr_at >= 0) begin
      @(posedge clk); #1;
      if (rdy_at >= 0) rdy = 1'b0;
      clr = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic set_row(input logic [RW-1:0] d, input logic [COL-1:0] v);
    rd.delete(); rv.delete();
    rd.push_back(d); rv.push_back(v);
  endtask

  initial begin
    // ---- reset state
    #3;
    chk("rst_valid", 32'(o_row_valid), 32'd0);
    chk("rst_row",   32'(o_row),       32'd0);
    chk("rst_count", 32'(o_row_count), 32'd0);
    chk("rst_ovf",   32'(o_overflow),  32'd0);
    chk("rst_err",   32'(o_err),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- single row: valid exactly in cycle t0+4
    rdy = 1'b1;
    set_row(24'hA1B2C3, 3'b111);
    sb.push_back(24'hA1B2C3);
    stream(1, -1, -1);
    @(negedge clk); chk("single_t3_valid", 32'(o_row_valid), 32'd0);
    @(negedge clk); chk("single_t4_valid", 32'(o_row_valid), 32'd1);
    chk("single_row", 32'(o_row), 32'hA1B2C3);
    @(negedge clk); chk("single_t5_valid", 32'(o_row_valid), 32'd0);
    chk("single_count", 32'(o_row_count), 32'd1);

    // ---- streaming 10 rows
    pulse_clr();
    chk("clr_count", 32'(o_row_count), 32'd0);
    rd.delete(); rv.delete();
    for (int k = 0; k < 10; k++) begin
      rd.push_back(24'h102030 + 24'(k) * 24'h010101);
      rv.push_back(3'b111);
      sb.push_back(24'h102030 + 24'(k) * 24'h010101);
    end
    pops = 0; max_run = 0;
    stream(10, -1, -1);
    repeat (4) @(negedge clk);
    chk("stream_pops",  32'(pops),        32'd10);
    chk("stream_run",   32'(max_run),     32'd10);
    chk("stream_count", 32'(o_row_count), 32'd10);
    chk("stream_ovf",   32'(o_overflow),  32'd0);
    chk("stream_err",   32'(o_err),       32'd0);

    // ---- overflow: 6 rows into 4 entries, no consumer
    pulse_clr();
    rdy = 1'b0;
    rd.delete(); rv.delete();
    for (int k = 0; k < 6; k++) begin
      rd.push_back(24'h400000 + 24'(k) * 24'h000111);
      rv.push_back(3'b111);
      if (k < 4) sb.push_back(24'h400000 + 24'(k) * 24'h000111);
    end
    stream(6, -1, -1);
    repeat (3) @(negedge clk);
    chk("ovf_count", 32'(o_row_count), 32'd4);
    chk("ovf_flag",  32'(o_overflow),  32'd1);
    chk("ovf_valid", 32'(o_row_valid), 32'd1);
    chk("ovf_hold",  32'(o_row),       32'h400000);
    // another drop on the same edge as i_clr: flag stays set, count cleared
    set_row(24'h777777, 3'b111);
    stream(1, -1, 3);
    @(negedge clk);
    chk("ovf_setwins", 32'(o_overflow),  32'd1);
    chk("ovf_clrcnt",  32'(o_row_count), 32'd0);
    pops = 0;
    rdy = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovf_drain_pops",  32'(pops),        32'd4);
    chk("ovf_drain_valid", 32'(o_row_valid), 32'd0);

    // ---- full FIFO, push and pop on the same edge
    pulse_clr();
    rdy = 1'b0;
    rd.delete(); rv.delete();
    for (int k = 0; k < 4; k++) begin
      rd.push_back(24'h500000 + 24'(k));
      rv.push_back(3'b111);
      sb.push_back(24'h500000 + 24'(k));
    end
    keep = rd[1];
    stream(4, -1, -1);
    repeat (2) @(negedge clk);
    set_row(24'h5ABCDE, 3'b111);
    sb.push_back(24'h5ABCDE);
    pops = 0;
    stream(1, 3, -1);
    @(negedge clk);
    chk("fpp_pops",  32'(pops),        32'd1);
    chk("fpp_valid", 32'(o_row_valid), 32'd1);
    chk("fpp_ovf",   32'(o_overflow),  32'd0);
    chk("fpp_count", 32'(o_row_count), 32'd5);
    chk("fpp_head",  32'(o_row),       32'(keep));
    rdy = 1'b1;
    repeat (6) @(negedge clk);
    chk("fpp_drain_pops", 32'(pops),        32'd5);
    chk("fpp_drain_sb",   32'(sb.size()),   32'd0);
    chk("fpp_empty",      32'(o_row_valid), 32'd0);

    // ---- partial row (lane 1 valid missing)
    pulse_clr();
    set_row(24'h112233, 3'b111);
    sb.push_back(24'h112233);
    stream(1, -1, -1);
    set_row(24'hD4E5F6, 3'b101);
`ifndef O_SA_COLLECT_SKEW_CHECK_EN
    sb.push_back(24'hD4E5F6);
`endif
    stream(1, -1, -1);
    repeat (3) @(negedge clk);
`ifdef O_SA_COLLECT_SKEW_CHECK_EN
    chk("skew_err",   32'(o_err),       32'd1);
    chk("skew_count", 32'(o_row_count), 32'd1);
`else
    chk("skew_err",   32'(o_err),       32'd0);
    chk("skew_count", 32'(o_row_count), 32'd2);
`endif
    // row write coinciding with i_clr: counter restarts at 1, err cleared
    set_row(24'h010203, 3'b111);
    sb.push_back(24'h010203);
    stream(1, -1, 3);
    repeat (2) @(negedge clk);
    chk("clrwr_count", 32'(o_row_count), 32'd1);
    chk("clr_err",     32'(o_err),       32'd0);
    chk("skew_sb",     32'(sb.size()),   32'd0);

    // ---- reset with 2 rows buffered and 1 in the deskew pipeline
    pulse_clr();
    rdy = 1'b0;
    rd.delete(); rv.delete();
    for (int k = 0; k < 2; k++) begin
      rd.push_back(24'h600000 + 24'(k));
      rv.push_back(3'b111);
    end
    stream(2, -1, -1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 din = {1'b1, 8'h99, 18'h0};
    @(posedge clk); #1 din = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(o_row_valid), 32'd0);
    chk("mrst_row",   32'(o_row),       32'd0);
    chk("mrst_count", 32'(o_row_count), 32'd0);
    chk("mrst_ovf",   32'(o_overflow),  32'd0);
    chk("mrst_err",   32'(o_err),       32'd0);
    rdy = 1'b1;
    pops = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mrst_nopop",  32'(pops),        32'd0);
    chk("mrst_quiet",  32'(o_row_valid), 32'd0);
    set_row(24'hFEDCBA, 3'b111);
    sb.push_back(24'hFEDCBA);
    stream(1, -1, -1);
    repeat (3) @(negedge clk);
    chk("mrst_new_pop",   32'(pops),        32'd1);
    chk("mrst_new_count", 32'(o_row_count), 32'd1);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
